// File: rtl/seg7_scanner.sv
// -----------------------------------------------------------------------------
// seg7_scanner
//
// Time-multiplexed seven-segment scanner. A full frame of per-digit segment
// patterns is accepted over a valid/ready handshake into a pending buffer and
// promoted to the displayed (active) frame only at the end of a full scan, so
// a frame is never shown half-updated. Each digit slot is REFRESH_DIV cycles
// long: BLANK_CYCLES with every anode off (anti-ghosting), then
// REFRESH_DIV-BLANK_CYCLES cycles driving one digit.
//
// Optional build macro: SEG7_BRIGHTNESS_EN
//   When defined, adds brightness_i[3:0]. During the drive part of a slot the
//   anode is only enabled for ((brightness_i+1)*DRIVE_CYCLES)>>4 cycles.
//   When undefined, the anode is enabled for the whole drive part.
//
// Ports:
//   clk_i             system clock
//   rst_ni            synchronous active-low reset
//   segments_i        frame; digit d = bits [8d+7:8d] = {dp,g,f,e,d,c,b,a},
//                     active-high
//   segments_valid_i  frame offered
//   brightness_i      (SEG7_BRIGHTNESS_EN only) anode duty within drive
//   segments_ready_o  pending buffer empty
//   an_no             anode enables, active-low, one-hot-low or all-high
//   seg_no            cathodes {g..a}, active-low
//   dp_no             decimal point, active-low
//   digit_o           index of the current digit slot
//   frame_done_o      one-cycle pulse on the last cycle of the final slot
// -----------------------------------------------------------------------------
module seg7_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_DIGITS*8-1:0]       segments_i,
    input  logic                          segments_valid_i,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]                    brightness_i,
`endif
    output logic                          segments_ready_o,
    output logic [NUM_DIGITS-1:0]         an_no,
    output logic [6:0]                    seg_no,
    output logic                          dp_no,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_o,
    output logic                          frame_done_o
);

    localparam int DIG_W        = $clog2(NUM_DIGITS);
    localparam int CNT_W        = $clog2(REFRESH_DIV + 1);
    localparam int DRIVE_CYCLES = REFRESH_DIV - BLANK_CYCLES;
    localparam int FRAME_W      = NUM_DIGITS * 8;

    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIGIT_LAST = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // With blanking disabled every slot starts (and stays) in DRIVE.
    localparam state_e SLOT_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIG_W-1:0]     digit_q, digit_d;
    logic                 wrap;

    logic [FRAME_W-1:0]   active_q, active_d;
    logic [FRAME_W-1:0]   pending_q, pending_d;
    logic                 pending_full_q, pending_full_d;
    logic                 accept;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic [7:0]            pattern;
    logic                  anode_on;
`ifdef SEG7_BRIGHTNESS_EN
    logic [31:0]           on_cycles;
`endif

    // ---------------------------------------------------------------------
    // Slot sequencer: BLANK -> DRIVE per digit, digit advances at the end of
    // DRIVE. The wrap cycle is the last DRIVE cycle of the last digit.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        wrap    = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = '0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == DRIVE_LAST) begin
                    state_d = SLOT_START;
                    cnt_d   = '0;
                    if (digit_q == DIGIT_LAST) begin
                        digit_d = '0;
                        wrap    = 1'b1;
                    end else begin
                        digit_d = digit_q + DIG_W'(1);
                    end
                end
            end
            default: begin
                state_d = SLOT_START;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Handshake: a frame transfers when segments_valid_i && segments_ready_o
    // at a rising edge; ready is simply "pending buffer empty" and does not
    // depend on valid. Valid may drop without a transfer. The pending frame
    // moves to active on the wrap cycle. Accept and commit cannot coincide:
    // accept needs the buffer empty, commit needs it full.
    // ---------------------------------------------------------------------
    assign accept = segments_valid_i && !pending_full_q;

    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (wrap && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_d      = segments_i;
            pending_full_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Registered outputs, derived from the next-state values so they always
    // match the state that is current after the same edge.
    // ---------------------------------------------------------------------
`ifdef SEG7_BRIGHTNESS_EN
    assign on_cycles = ((32'(brightness_i) + 32'd1) * 32'(DRIVE_CYCLES)) >> 4;
    assign anode_on  = (state_d == ST_DRIVE) && (32'(cnt_d) < on_cycles);
`else
    assign anode_on  = (state_d == ST_DRIVE);
`endif

    always_comb begin
        pattern = 8'h00;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (digit_d == DIG_W'(d)) begin
                pattern = active_d[8*d +: 8];
            end
        end
    end

    always_comb begin
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_done_d = (state_d == ST_DRIVE) && (cnt_d == DRIVE_LAST) &&
                       (digit_d == DIGIT_LAST);
        if (anode_on) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                an_d[d] = (digit_d != DIG_W'(d));
            end
        end
        // Cathodes follow DRIVE regardless of dimming.
        if (state_d == ST_DRIVE) begin
            seg_d = ~pattern[6:0];
            dp_d  = ~pattern[7];
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= SLOT_START;
            cnt_q          <= '0;
            digit_q        <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            an_q           <= '1;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign segments_ready_o = !pending_full_q;
    assign an_no            = an_q;
    assign seg_no           = seg_q;
    assign dp_no            = dp_q;
    assign digit_o          = digit_q;
    assign frame_done_o     = frame_done_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg7_scanner
//
// Directed bench for seg7_scanner with NUM_DIGITS=4, REFRESH_DIV=10,
// BLANK_CYCLES=2. Cycle k counts from the first clock interval after reset
// release; outputs are sampled on the falling edge, inputs change 1 time unit
// after the rising edge. Build with +define+SEG7_BRIGHTNESS_EN to include the
// dimming scenario.
// -----------------------------------------------------------------------------
module tb_seg7_scanner;

    localparam int ND = 4;
    localparam int RD = 10;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] seg_in = 32'h0;
    logic        valid = 1'b0;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  bright = 4'd15;
`endif

    logic        ready;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [1:0]  digit;
    logic        fdone;

    int errors = 0;
    int checks = 0;

    // Hand-computed cathode/dp patterns per digit for the test frames.
    // 32'h805B063F
    logic [6:0] f1_seg [4] = '{7'h40, 7'h79, 7'h24, 7'h7F};
    logic       f1_dp  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    // A = 32'h01020408
    localparam logic [31:0] FRAME_A = 32'h01020408;
    logic [6:0] a_seg  [4] = '{7'h77, 7'h7B, 7'h7D, 7'h7E};
    logic       a_dp   [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    // B = 32'h80402010
    localparam logic [31:0] FRAME_B = 32'h80402010;
    logic [6:0] b_seg  [4] = '{7'h6F, 7'h5F, 7'h3F, 7'h7F};
    logic       b_dp   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    seg7_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .segments_i      (seg_in),
        .segments_valid_i(valid),
`ifdef SEG7_BRIGHTNESS_EN
        .brightness_i    (bright),
`endif
        .segments_ready_o(ready),
        .an_no           (an_n),
        .seg_no          (seg_n),
        .dp_no           (dp_n),
        .digit_o         (digit),
        .frame_done_o    (fdone)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- timing model ----------------
    function automatic int slot_of(int k);
        return (k / RD) % ND;
    endfunction

    function automatic bit driving(int k);
        return (k % RD) >= BC;
    endfunction

    function automatic logic [3:0] exp_an(int k);
        logic [3:0] one;
        one = 4'b0001 << slot_of(k);
        return driving(k) ? ~one : 4'hF;
    endfunction

    function automatic logic exp_fd(int k);
        return (k % (ND * RD)) == (ND * RD - 1);
    endfunction

    // Hold reset for n edges, release just after a rising edge (start of cycle 0).
    task automatic do_reset(int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n  = 1'b0;
        valid  = 1'b1;
        seg_in = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL reset_an got=%h exp=f", an_n); end
            checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%h exp=7f", seg_n); end
            checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
            checks++; if (digit !== 2'd0) begin errors++; $display("FAIL reset_digit got=%0d exp=0", digit); end
            checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL reset_fdone got=%b exp=0", fdone); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid = 1'b0;
    endtask

    // Runs straight after test_reset: nothing offered during reset may show up.
    task automatic test_timing();
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            checks++; if (an_n !== exp_an(k)) begin errors++; $display("FAIL timing_an k=%0d got=%h exp=%h", k, an_n, exp_an(k)); end
            checks++; if (digit !== 2'(slot_of(k))) begin errors++; $display("FAIL timing_digit k=%0d got=%0d exp=%0d", k, digit, slot_of(k)); end
            checks++; if (fdone !== exp_fd(k)) begin errors++; $display("FAIL timing_fdone k=%0d got=%b exp=%b", k, fdone, exp_fd(k)); end
            checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL timing_seg k=%0d got=%h exp=7f", k, seg_n); end
            checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL timing_dp k=%0d got=%b exp=1", k, dp_n); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL timing_ready k=%0d got=%b exp=1", k, ready); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_frame_display();
        logic [6:0] es;
        logic       ed;
        logic       er;
        do_reset(3);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            er = !(k >= 4 && k <= 39);
            es = (k >= 40 && driving(k)) ? f1_seg[slot_of(k)] : 7'h7F;
            ed = (k >= 40 && driving(k)) ? f1_dp[slot_of(k)] : 1'b1;
            checks++; if (ready !== er) begin errors++; $display("FAIL frame_ready k=%0d got=%b exp=%b", k, ready, er); end
            checks++; if (an_n !== exp_an(k)) begin errors++; $display("FAIL frame_an k=%0d got=%h exp=%h", k, an_n, exp_an(k)); end
            checks++; if (seg_n !== es) begin errors++; $display("FAIL frame_seg k=%0d got=%h exp=%h", k, seg_n, es); end
            checks++; if (dp_n !== ed) begin errors++; $display("FAIL frame_dp k=%0d got=%b exp=%b", k, dp_n, ed); end
            checks++; if (fdone !== exp_fd(k)) begin errors++; $display("FAIL frame_fdone k=%0d got=%b exp=%b", k, fdone, exp_fd(k)); end
            @(posedge clk);
            #1;
            if (k == 2) begin
                valid  = 1'b1;
                seg_in = 32'h805B063F;
            end
            if (k == 3) begin
                valid  = 1'b0;
                seg_in = 32'hDEADBEEF;
            end
        end
    endtask

    // A accepted, B held valid: B must wait for A's commit; frames never mix.
    task automatic test_back_to_back();
        int         acc_a;
        int         acc_b;
        bit         acc;
        logic [6:0] es;
        logic       ed;
        logic       er;
        int         f;
        acc_a = -1;
        acc_b = -1;
        do_reset(3);
        valid  = 1'b1;
        seg_in = FRAME_A;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            acc = valid && ready;
            f   = k / (ND * RD);
            er  = (k == 0) || (k == 40) || (k >= 80);
            es  = 7'h7F;
            ed  = 1'b1;
            if (driving(k) && f == 1) begin
                es = a_seg[slot_of(k)];
                ed = a_dp[slot_of(k)];
            end else if (driving(k) && f == 2) begin
                es = b_seg[slot_of(k)];
                ed = b_dp[slot_of(k)];
            end
            checks++; if (ready !== er) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, ready, er); end
            checks++; if (seg_n !== es) begin errors++; $display("FAIL b2b_seg k=%0d got=%h exp=%h", k, seg_n, es); end
            checks++; if (dp_n !== ed) begin errors++; $display("FAIL b2b_dp k=%0d got=%b exp=%b", k, dp_n, ed); end
            checks++; if (an_n !== exp_an(k)) begin errors++; $display("FAIL b2b_an k=%0d got=%h exp=%h", k, an_n, exp_an(k)); end
            checks++; if (fdone !== exp_fd(k)) begin errors++; $display("FAIL b2b_fdone k=%0d got=%b exp=%b", k, fdone, exp_fd(k)); end
            if (acc) begin
                if (acc_a < 0) acc_a = k;
                else           acc_b = k;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (k == acc_a) seg_in = FRAME_B;
                else            valid  = 1'b0;
            end
        end
        checks++; if (acc_a != 0) begin errors++; $display("FAIL b2b_accept_a got=%0d exp=0", acc_a); end
        checks++; if (acc_b != 40) begin errors++; $display("FAIL b2b_accept_b got=%0d exp=40", acc_b); end
        valid = 1'b0;
    endtask

    // A displayed, B pending; reset during DRIVE of digit 2 drops both.
    task automatic test_reset_mid_drive();
        bit acc;
        bit a_done;
        a_done = 1'b0;
        do_reset(3);
        valid  = 1'b1;
        seg_in = FRAME_A;
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            acc = valid && ready;
            if (k == 65) begin
                checks++; if (an_n !== 4'b1011) begin errors++; $display("FAIL mid_an_before got=%h exp=b", an_n); end
                checks++; if (digit !== 2'd2) begin errors++; $display("FAIL mid_digit_before got=%0d exp=2", digit); end
                checks++; if (seg_n !== 7'h7D) begin errors++; $display("FAIL mid_seg_before got=%h exp=7d", seg_n); end
                checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready_before got=%b exp=0", ready); end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (!a_done) begin
                    a_done = 1'b1;
                    seg_in = FRAME_B;
                end else begin
                    valid = 1'b0;
                end
            end
        end
        valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (an_n !== 4'hF) begin errors++; $display("FAIL mid_reset_an got=%h exp=f", an_n); end
        checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL mid_reset_seg got=%h exp=7f", seg_n); end
        checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL mid_reset_dp got=%b exp=1", dp_n); end
        checks++; if (digit !== 2'd0) begin errors++; $display("FAIL mid_reset_digit got=%0d exp=0", digit); end
        checks++; if (fdone !== 1'b0) begin errors++; $display("FAIL mid_reset_fdone got=%b exp=0", fdone); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", ready); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            checks++; if (an_n !== exp_an(k)) begin errors++; $display("FAIL mid_after_an k=%0d got=%h exp=%h", k, an_n, exp_an(k)); end
            checks++; if (digit !== 2'(slot_of(k))) begin errors++; $display("FAIL mid_after_digit k=%0d got=%0d exp=%0d", k, digit, slot_of(k)); end
            checks++; if (seg_n !== 7'h7F) begin errors++; $display("FAIL mid_after_seg k=%0d got=%h exp=7f", k, seg_n); end
            checks++; if (dp_n !== 1'b1) begin errors++; $display("FAIL mid_after_dp k=%0d got=%b exp=1", k, dp_n); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready k=%0d got=%b exp=1", k, ready); end
            checks++; if (fdone !== exp_fd(k)) begin errors++; $display("FAIL mid_after_fdone k=%0d got=%b exp=%b", k, fdone, exp_fd(k)); end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef SEG7_BRIGHTNESS_EN
    task automatic test_brightness();
        logic [3:0] lvl [3] = '{4'd3, 4'd15, 4'd0};
        int         on  [3] = '{2, 8, 0};
        logic [3:0] ea;
        int         lows;
        int         ph;
        for (int t = 0; t < 3; t++) begin
            bright = lvl[t];
            lows   = 0;
            do_reset(3);
            for (int k = 0; k < 80; k++) begin
                @(negedge clk);
                ph = k % RD;
                ea = (ph >= BC && (ph - BC) < on[t]) ? exp_an(k) : 4'hF;
                if (an_n !== 4'hF) lows++;
                checks++; if (an_n !== ea) begin errors++; $display("FAIL bright_an lvl=%0d k=%0d got=%h exp=%h", lvl[t], k, an_n, ea); end
                checks++; if (fdone !== exp_fd(k)) begin errors++; $display("FAIL bright_fdone lvl=%0d k=%0d got=%b exp=%b", lvl[t], k, fdone, exp_fd(k)); end
                @(posedge clk);
                #1;
            end
            checks++; if (lows != on[t] * 8) begin errors++; $display("FAIL bright_count lvl=%0d got=%0d exp=%0d", lvl[t], lows, on[t] * 8); end
        end
        bright = 4'd15;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_timing();
        test_frame_display();
        test_back_to_back();
        test_reset_mid_drive();
`ifdef SEG7_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
